// File: rtl/huff_code_packer.sv
// Packs variable-length Huffman codes (table loaded from huff_encoder beats) MSB-first
// into bytes, with flush padding of the final partial byte.
module huff_code_packer #(
  parameter int unsigned NUM_SYM = 3,
  parameter int unsigned CODE_W  = 3,
  parameter int unsigned OUT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [11:0]      enc_in,
  input  logic             table_clear,
  output logic             table_ready,
  input  logic             sym_valid,
  input  logic [1:0]       sym_idx,
  output logic             sym_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             flush_done,
  output logic             err_sym
);

  localparam int unsigned ACC_W    = OUT_W + CODE_W - 1;
  localparam int unsigned CNT_W    = $clog2(ACC_W + 1);
  localparam int unsigned LEN_W    = $clog2(CODE_W + 1);
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned TBL_N    = 2 ** IDX_W;
  localparam int unsigned DONE_BIT = 8;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   load_idx_q, load_idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               table_ready_q, table_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               err_sym_q, err_sym_d;
  logic [CODE_W-1:0]  mask_q [TBL_N];
  logic [CODE_W-1:0]  mask_d [TBL_N];
  logic [CODE_W-1:0]  val_q  [TBL_N];
  logic [CODE_W-1:0]  val_d  [TBL_N];

  logic [CODE_W-1:0]  enc_mask, enc_val, sel_mask, sel_val;
  logic [LEN_W-1:0]   sym_len;
  logic               sym_hs, cnt_full, out_free;
  logic [OUT_W-1:0]   full_byte, pad_byte;
  logic               unused_enc;

  assign enc_mask   = enc_in[2*CODE_W-1:CODE_W];
  assign enc_val    = enc_in[CODE_W-1:0];
  assign unused_enc = ^{enc_in[11:9], enc_in[7:6]};

  // Selected table entry and its code length (popcount of the thermometer mask)
  always_comb begin
    sel_mask = mask_q[sym_idx];
    sel_val  = val_q[sym_idx];
    sym_len  = '0;
    for (int i = 0; i < CODE_W; i++) begin
      sym_len = sym_len + LEN_W'(sel_mask[i]);
    end
  end

  assign sym_ready = (state_q == S_RUN) && (cnt_q < CNT_W'(OUT_W));
  assign sym_hs    = sym_valid && sym_ready;
  assign cnt_full  = (cnt_q >= CNT_W'(OUT_W));
  assign out_free  = !out_valid_q || out_ready;
  // Oldest OUT_W valid bits, and the partial remainder left-aligned with zero fill
  assign full_byte = OUT_W'(acc_q >> (cnt_q - CNT_W'(OUT_W)));
  assign pad_byte  = OUT_W'(acc_q << (CNT_W'(OUT_W) - cnt_q));

  always_comb begin
    state_d       = state_q;
    load_idx_d    = load_idx_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    table_ready_d = table_ready_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    err_sym_d     = err_sym_q;
    mask_d        = mask_q;
    val_d         = val_q;
    flush_done    = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      S_LOAD: begin
        if (enc_in[DONE_BIT]) begin
          mask_d[load_idx_q] = enc_mask;
          val_d[load_idx_q]  = enc_val;
          load_idx_d         = load_idx_q + IDX_W'(1);
          if (load_idx_q == IDX_W'(NUM_SYM - 1)) begin
            table_ready_d = 1'b1;
            state_d       = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (sym_hs) begin
          if (sym_idx < IDX_W'(NUM_SYM)) begin
            acc_d = (acc_q << sym_len) | ACC_W'(sel_val & sel_mask);
            cnt_d = cnt_q + CNT_W'(sym_len);
          end else begin
            err_sym_d = 1'b1;
          end
        end else if (cnt_full && out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = full_byte;
          out_last_d  = 1'b0;
          cnt_d       = cnt_q - CNT_W'(OUT_W);
        end
        if (flush) begin
          state_d = S_FLUSH;
        end else if (table_clear && (cnt_q == '0) && !out_valid_q && !sym_hs) begin
          for (int i = 0; i < TBL_N; i++) begin
            mask_d[i] = '0;
            val_d[i]  = '0;
          end
          table_ready_d = 1'b0;
          load_idx_d    = '0;
          state_d       = S_LOAD;
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          if (cnt_full) begin
            out_valid_d = 1'b1;
            out_data_d  = full_byte;
            out_last_d  = 1'b0;
            cnt_d       = cnt_q - CNT_W'(OUT_W);
          end else if (cnt_q != '0) begin
            out_valid_d = 1'b1;
            out_data_d  = pad_byte;
            out_last_d  = 1'b1;
            cnt_d       = '0;
          end else begin
            flush_done = 1'b1;
            state_d    = S_RUN;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_LOAD;
      load_idx_q    <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      table_ready_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      err_sym_q     <= 1'b0;
      for (int i = 0; i < TBL_N; i++) begin
        mask_q[i] <= '0;
        val_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      load_idx_q    <= load_idx_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      table_ready_q <= table_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      err_sym_q     <= err_sym_d;
      mask_q        <= mask_d;
      val_q         <= val_d;
    end
  end

  assign table_ready = table_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign err_sym     = err_sym_q;

endmodule

// File: tb/tb_huff_code_packer.sv
// Self-checking bench for huff_code_packer: directed scenarios plus randomized streams
// compared against a bit-queue reference model.
module tb_huff_code_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] enc_in = '0;
  logic        table_clear = 1'b0;
  logic        table_ready;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym_idx = '0;
  logic        sym_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        flush_done;
  logic        err_sym;

  always #5 clk = ~clk;

  huff_code_packer dut (
    .clk(clk), .reset_n(reset_n), .enc_in(enc_in), .table_clear(table_clear),
    .table_ready(table_ready), .sym_valid(sym_valid), .sym_idx(sym_idx),
    .sym_ready(sym_ready), .flush(flush), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .flush_done(flush_done), .err_sym(err_sym)
  );

  int tests = 0;
  int fails = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  bit         mbits[$];
  logic [2:0] tm_mask[4];
  logic [2:0] tm_val[4];
  int fd_cnt = 0;
  bit hs = 1'b0;
  bit rand_bp = 1'b0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: sample handshakes just after inputs settle, then advance past the edge
  task automatic cycle();
    #1;
    hs = sym_valid && sym_ready;
    if (out_valid && out_ready) got_q.push_back({out_last, out_data});
    if (flush_done) fd_cnt++;
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic model_push(input int idx);
    logic [7:0] by;
    int len;
    if (idx < 3) begin
      len = $countones(tm_mask[idx]);
      for (int b = len - 1; b >= 0; b--) mbits.push_back(tm_val[idx][b]);
    end
    while (mbits.size() >= 8) begin
      for (int k = 7; k >= 0; k--) by[k] = mbits.pop_front();
      exp_q.push_back({1'b0, by});
    end
  endtask

  task automatic model_flush();
    logic [7:0] by;
    if (mbits.size() > 0) begin
      by = '0;
      for (int k = 0; k < mbits.size(); k++) by[7-k] = mbits[k];
      exp_q.push_back({1'b1, by});
      mbits.delete();
    end
  endtask

  task automatic send_sym(input int idx);
    sym_valid = 1'b1;
    sym_idx   = 2'(idx);
    hs        = 1'b0;
    for (int k = 0; k < 100 && !hs; k++) cycle();
    sym_valid = 1'b0;
    tests++;
    if (!hs) begin
      fails++;
      $display("FAIL sym_handshake: idx=%0d not accepted within 100 cycles", idx);
    end else begin
      model_push(idx);
    end
  endtask

  task automatic do_flush();
    fd_cnt = 0;
    flush  = 1'b1;
    cycle();
    flush  = 1'b0;
    for (int k = 0; k < 300 && fd_cnt == 0; k++) cycle();
    repeat (3) cycle();
    model_flush();
    tests++;
    if (fd_cnt != 1) begin
      fails++;
      $display("FAIL flush_done_count: got %0d expected 1", fd_cnt);
    end
  endtask

  task automatic compare_stream(input string name);
    int n;
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s byte_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL %s byte%0d: got last=%0b data=%02h expected last=%0b data=%02h",
                 name, i, got_q[i][8], got_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_clear();
    table_clear = 1'b1;
    cycle();
    table_clear = 1'b0;
    cycle();
  endtask

  task automatic load_table(input logic [11:0] b0, input logic [11:0] b1, input logic [11:0] b2);
    logic [11:0] bt[3];
    bt[0] = b0; bt[1] = b1; bt[2] = b2;
    for (int i = 0; i < 3; i++) begin
      enc_in = bt[i];
      cycle();
      tm_mask[i] = bt[i][5:3];
      tm_val[i]  = bt[i][2:0];
    end
    enc_in = '0;
    cycle();
    tests++;
    if (table_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_table_ready: got %0b expected 1", table_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({table_ready, sym_ready, out_valid, out_data, out_last, flush_done, err_sym} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got tr=%0b sr=%0b ov=%0b od=%02h ol=%0b fd=%0b err=%0b expected all 0",
               table_ready, sym_ready, out_valid, out_data, out_last, flush_done, err_sym);
    end
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic test_load();
    enc_in = 12'h009;
    repeat (2) cycle();
    enc_in = 12'h109; cycle();
    enc_in = 12'h11A; cycle();
    enc_in = 12'h01B; cycle();
    enc_in = '0;
    tests++;
    if (table_ready !== 1'b0) begin
      fails++;
      $display("FAIL load_partial_ready: got %0b expected 0", table_ready);
    end
    enc_in = 12'h11B; cycle();
    enc_in = '0;
    tests++;
    if (table_ready !== 1'b1 || sym_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_complete: got tr=%0b sr=%0b expected 1 1", table_ready, sym_ready);
    end
    tm_mask[0] = 3'b001; tm_val[0] = 3'b001;
    tm_mask[1] = 3'b011; tm_val[1] = 3'b010;
    tm_mask[2] = 3'b011; tm_val[2] = 3'b011;
    enc_in = 12'h100; cycle();
    enc_in = '0;
    tests++;
    if (table_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_extra_beat: got tr=%0b expected 1", table_ready);
    end
    send_sym(2); send_sym(1); send_sym(0);
    do_flush();
    compare_stream("load_table_contents");
  endtask

  task automatic test_stream();
    int seq[6] = '{0, 1, 2, 0, 1, 2};
    do_clear();
    load_table(12'h108, 12'h11A, 12'h11B);
    foreach (seq[i]) send_sym(seq[i]);
    do_flush();
    tests++;
    if (got_q.size() != 2 || got_q[0] !== 9'h05A || got_q[1] !== 9'h1C0) begin
      fails++;
      $display("FAIL stream_fixed: got %0d bytes first=%03h expected 05A,1C0",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h0);
    end
    compare_stream("stream");
  endtask

  task automatic test_backpressure();
    bit any_hs;
    out_ready = 1'b0;
    repeat (8) send_sym(2);
    repeat (3) cycle();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF || out_last !== 1'b0 || sym_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_hold: got ov=%0b od=%02h ol=%0b sr=%0b expected 1 FF 0 0",
               out_valid, out_data, out_last, sym_ready);
    end
    sym_valid = 1'b1;
    sym_idx   = 2'd2;
    any_hs    = 1'b0;
    repeat (4) begin
      cycle();
      any_hs |= hs;
    end
    tests++;
    if (any_hs) begin
      fails++;
      $display("FAIL bp_sym_blocked: got handshake=1 expected 0");
    end
    out_ready = 1'b1;
    send_sym(2);
    send_sym(2);
    do_flush();
    tests++;
    if (got_q.size() != 3 || got_q[2] !== 9'h1F0) begin
      fails++;
      $display("FAIL bp_tail: got %0d bytes expected 3 ending 1F0", got_q.size());
    end
    compare_stream("backpressure");
  endtask

  task automatic test_err_zero_len();
    tests++;
    if (err_sym !== 1'b0) begin
      fails++;
      $display("FAIL err_initial: got %0b expected 0", err_sym);
    end
    send_sym(3);
    cycle();
    tests++;
    if (err_sym !== 1'b1) begin
      fails++;
      $display("FAIL err_set: got %0b expected 1", err_sym);
    end
    do_flush();
    do_clear();
    load_table(12'h100, 12'h11A, 12'h11B);
    send_sym(0); send_sym(1); send_sym(0); send_sym(2); send_sym(0);
    do_flush();
    tests++;
    if (err_sym !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: got %0b expected 1", err_sym);
    end
    compare_stream("zero_len");
  endtask

  task automatic test_mid_reset();
    bit any_hs;
    do_clear();
    load_table(12'h108, 12'h11A, 12'h11B);
    out_ready = 1'b0;
    repeat (4) send_sym(2);
    send_sym(2); send_sym(2); send_sym(0);
    repeat (2) cycle();
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL mreset_pre: got ov=%0b expected 1", out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({table_ready, sym_ready, out_valid, out_data, out_last, flush_done, err_sym} !== '0) begin
      fails++;
      $display("FAIL mreset_async: got tr=%0b sr=%0b ov=%0b od=%02h ol=%0b fd=%0b err=%0b expected all 0",
               table_ready, sym_ready, out_valid, out_data, out_last, flush_done, err_sym);
    end
    mbits.delete(); got_q.delete(); exp_q.delete();
    cycle();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    cycle();
    sym_valid = 1'b1;
    sym_idx   = 2'd0;
    any_hs    = 1'b0;
    repeat (3) begin
      cycle();
      any_hs |= hs;
    end
    sym_valid = 1'b0;
    tests++;
    if (table_ready !== 1'b0 || any_hs) begin
      fails++;
      $display("FAIL mreset_load_state: got tr=%0b hs=%0b expected 0 0", table_ready, any_hs);
    end
    load_table(12'h109, 12'h11A, 12'h11B);
    send_sym(1); send_sym(2); send_sym(0);
    do_flush();
    compare_stream("after_reset");
  endtask

  task automatic test_flush_empty_and_clear();
    out_ready = 1'b1;
    fd_cnt = 0;
    flush  = 1'b1;
    cycle();
    flush  = 1'b0;
    cycle();
    tests++;
    if (fd_cnt != 1 || got_q.size() != 0) begin
      fails++;
      $display("FAIL flush_empty: got fd=%0d bytes=%0d expected 1 0", fd_cnt, got_q.size());
    end
    cycle();
    tests++;
    if (fd_cnt != 1 || sym_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_empty_return: got fd=%0d sr=%0b expected 1 1", fd_cnt, sym_ready);
    end
    do_clear();
    tests++;
    if (table_ready !== 1'b0 || sym_ready !== 1'b0) begin
      fails++;
      $display("FAIL clear_idle: got tr=%0b sr=%0b expected 0 0", table_ready, sym_ready);
    end
    load_table(12'h109, 12'h108, 12'h11B);
    send_sym(0); send_sym(1); send_sym(2); send_sym(1);
    do_flush();
    compare_stream("reload");
  endtask

  task automatic test_random();
    logic [11:0] bt[3];
    int len;
    rand_bp = 1'b1;
    for (int r = 0; r < 5; r++) begin
      do_clear();
      for (int i = 0; i < 3; i++) begin
        len   = $urandom_range(0, 3);
        bt[i] = {3'($urandom), 1'b1, 2'($urandom), 3'((1 << len) - 1), 3'($urandom)};
      end
      load_table(bt[0], bt[1], bt[2]);
      for (int s = 0; s < 30; s++) begin
        send_sym($urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) cycle();
      end
      do_flush();
      compare_stream("random");
    end
    rand_bp   = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_backpressure();
    test_err_zero_len();
    test_mid_reset();
    test_flush_empty_and_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
